// File: rtl/red_frame_ctrl.sv
// red_frame_ctrl: frame-level controller for the red-pixel detector.
// Owns the colour thresholds (shadow + active), tracks raster position of
// the detector output stream, accumulates red count and bounding box per
// frame and hands each frame result downstream over valid/ready.
//
// Handshake: a result is transferred on any cycle where o_res_valid and
// i_res_ready are both high; o_res_valid then drops the next cycle unless a
// new frame completes in that same cycle. Result fields never change while
// o_res_valid is high except when a newer frame result replaces them.
module red_frame_ctrl #(
    parameter int IMG_W     = 640,
    parameter int IMG_H     = 480,
    parameter int XW        = 10,
    parameter int YW        = 9,
    parameter int CW        = 19,
    parameter int MIN_COUNT = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_cfg_we,
    input  logic [4:0]    i_cfg_r_min,
    input  logic [5:0]    i_cfg_g_max,
    input  logic [4:0]    i_cfg_b_max,
    output logic [4:0]    o_r_min,
    output logic [5:0]    o_g_max,
    output logic [4:0]    o_b_max,
    input  logic          i_valid,
    input  logic          i_sof,
    input  logic          i_pixel_is_red,
    output logic          o_busy,
    output logic          o_res_valid,
    input  logic          i_res_ready,
    output logic          o_res_found,
    output logic [XW-1:0] o_res_xmin,
    output logic [XW-1:0] o_res_xmax,
    output logic [YW-1:0] o_res_ymin,
    output logic [YW-1:0] o_res_ymax,
    output logic [CW-1:0] o_res_count,
    output logic          o_overrun,
    output logic          o_sync_err
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    localparam logic [4:0] R_MIN_RST = 5'd27;
    localparam logic [5:0] G_MAX_RST = 6'd12;
    localparam logic [4:0] B_MAX_RST = 5'd8;
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
    localparam logic [CW-1:0] CNT_MIN = CW'(MIN_COUNT);

    state_e        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          box_vld_q, box_vld_d;
    logic [XW-1:0] bxmin_q, bxmin_d, bxmax_q, bxmax_d;
    logic [YW-1:0] bymin_q, bymin_d, bymax_q, bymax_d;
    logic [4:0]    sh_r_q, sh_r_d, act_r_q, act_r_d;
    logic [5:0]    sh_g_q, sh_g_d, act_g_q, act_g_d;
    logic [4:0]    sh_b_q, sh_b_d, act_b_q, act_b_d;
    logic          res_valid_q, res_valid_d;
    logic          res_found_q, res_found_d;
    logic [XW-1:0] res_xmin_q, res_xmin_d, res_xmax_q, res_xmax_d;
    logic [YW-1:0] res_ymin_q, res_ymin_d, res_ymax_q, res_ymax_d;
    logic [CW-1:0] res_cnt_q, res_cnt_d;
    logic          overrun_q, overrun_d;
    logic          sync_err_q, sync_err_d;

    // Beat-level helpers: an SOF beat restarts position and accumulators.
    logic          sof_beat;
    logic          beat_go;
    logic          last_beat;
    logic          complete;
    logic [XW-1:0] cur_x;
    logic [YW-1:0] cur_y;
    logic [CW-1:0] base_cnt;
    logic          base_bv;

    // Next-state, datapath and result-latch logic.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        cnt_d       = cnt_q;
        box_vld_d   = box_vld_q;
        bxmin_d     = bxmin_q;
        bxmax_d     = bxmax_q;
        bymin_d     = bymin_q;
        bymax_d     = bymax_q;
        sh_r_d      = sh_r_q;
        sh_g_d      = sh_g_q;
        sh_b_d      = sh_b_q;
        act_r_d     = act_r_q;
        act_g_d     = act_g_q;
        act_b_d     = act_b_q;
        res_valid_d = res_valid_q;
        res_found_d = res_found_q;
        res_xmin_d  = res_xmin_q;
        res_xmax_d  = res_xmax_q;
        res_ymin_d  = res_ymin_q;
        res_ymax_d  = res_ymax_q;
        res_cnt_d   = res_cnt_q;
        overrun_d   = 1'b0;
        sync_err_d  = 1'b0;
        complete    = 1'b0;

        sof_beat  = i_valid & i_sof;
        beat_go   = sof_beat | (i_valid & (state_q == ACTIVE));
        cur_x     = sof_beat ? '0 : x_q;
        cur_y     = sof_beat ? '0 : y_q;
        base_cnt  = sof_beat ? '0 : cnt_q;
        base_bv   = sof_beat ? 1'b0 : box_vld_q;
        last_beat = (cur_x == X_LAST) && (cur_y == Y_LAST);

        // SOF arriving mid-frame aborts the partial frame.
        if (sof_beat && (state_q == ACTIVE) && ((x_q != '0) || (y_q != '0))) begin
            sync_err_d = 1'b1;
        end

        // Active thresholds only change on an SOF beat; a coincident host
        // write bypasses the shadow so it takes effect for this frame.
        if (sof_beat) begin
            act_r_d = i_cfg_we ? i_cfg_r_min : sh_r_q;
            act_g_d = i_cfg_we ? i_cfg_g_max : sh_g_q;
            act_b_d = i_cfg_we ? i_cfg_b_max : sh_b_q;
        end
        if (i_cfg_we) begin
            sh_r_d = i_cfg_r_min;
            sh_g_d = i_cfg_g_max;
            sh_b_d = i_cfg_b_max;
        end

        if (beat_go) begin
            cnt_d     = base_cnt;
            box_vld_d = base_bv;
            if (sof_beat) begin
                bxmin_d = '0;
                bxmax_d = '0;
                bymin_d = '0;
                bymax_d = '0;
            end
            if (i_pixel_is_red) begin
                cnt_d = base_cnt + CW'(1);
                if (!base_bv) begin
                    box_vld_d = 1'b1;
                    bxmin_d   = cur_x;
                    bxmax_d   = cur_x;
                    bymin_d   = cur_y;
                    bymax_d   = cur_y;
                end else begin
                    if (cur_x < bxmin_q) bxmin_d = cur_x;
                    if (cur_x > bxmax_q) bxmax_d = cur_x;
                    if (cur_y < bymin_q) bymin_d = cur_y;
                    if (cur_y > bymax_q) bymax_d = cur_y;
                end
            end
            if (last_beat) begin
                complete = 1'b1;
                state_d  = IDLE;
                x_d      = '0;
                y_d      = '0;
            end else begin
                state_d = ACTIVE;
                if (cur_x == X_LAST) begin
                    x_d = '0;
                    y_d = cur_y + YW'(1);
                end else begin
                    x_d = cur_x + XW'(1);
                    y_d = cur_y;
                end
            end
        end

        // Result latch and downstream handshake.
        if (complete) begin
            res_valid_d = 1'b1;
            res_cnt_d   = cnt_d;
            res_found_d = (cnt_d >= CNT_MIN);
            res_xmin_d  = res_found_d ? bxmin_d : '0;
            res_xmax_d  = res_found_d ? bxmax_d : '0;
            res_ymin_d  = res_found_d ? bymin_d : '0;
            res_ymax_d  = res_found_d ? bymax_d : '0;
            overrun_d   = res_valid_q & ~i_res_ready;
        end else if (res_valid_q && i_res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    // State and data registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            cnt_q       <= '0;
            box_vld_q   <= 1'b0;
            bxmin_q     <= '0;
            bxmax_q     <= '0;
            bymin_q     <= '0;
            bymax_q     <= '0;
            sh_r_q      <= R_MIN_RST;
            sh_g_q      <= G_MAX_RST;
            sh_b_q      <= B_MAX_RST;
            act_r_q     <= R_MIN_RST;
            act_g_q     <= G_MAX_RST;
            act_b_q     <= B_MAX_RST;
            res_valid_q <= 1'b0;
            res_found_q <= 1'b0;
            res_xmin_q  <= '0;
            res_xmax_q  <= '0;
            res_ymin_q  <= '0;
            res_ymax_q  <= '0;
            res_cnt_q   <= '0;
            overrun_q   <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            cnt_q       <= cnt_d;
            box_vld_q   <= box_vld_d;
            bxmin_q     <= bxmin_d;
            bxmax_q     <= bxmax_d;
            bymin_q     <= bymin_d;
            bymax_q     <= bymax_d;
            sh_r_q      <= sh_r_d;
            sh_g_q      <= sh_g_d;
            sh_b_q      <= sh_b_d;
            act_r_q     <= act_r_d;
            act_g_q     <= act_g_d;
            act_b_q     <= act_b_d;
            res_valid_q <= res_valid_d;
            res_found_q <= res_found_d;
            res_xmin_q  <= res_xmin_d;
            res_xmax_q  <= res_xmax_d;
            res_ymin_q  <= res_ymin_d;
            res_ymax_q  <= res_ymax_d;
            res_cnt_q   <= res_cnt_d;
            overrun_q   <= overrun_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign o_r_min     = act_r_q;
    assign o_g_max     = act_g_q;
    assign o_b_max     = act_b_q;
    assign o_busy      = (state_q == ACTIVE);
    assign o_res_valid = res_valid_q;
    assign o_res_found = res_found_q;
    assign o_res_xmin  = res_xmin_q;
    assign o_res_xmax  = res_xmax_q;
    assign o_res_ymin  = res_ymin_q;
    assign o_res_ymax  = res_ymax_q;
    assign o_res_count = res_cnt_q;
    assign o_overrun   = overrun_q;
    assign o_sync_err  = sync_err_q;

endmodule

// File: tb/tb_red_frame_ctrl.sv
// Testbench for red_frame_ctrl with an 8x4 frame and MIN_COUNT=2.
// A frame-level model (beat index + list of red positions) predicts every
// output each cycle; a few literal expectations pin the model.
module tb_red_frame_ctrl;

    localparam int IMG_W = 8;
    localparam int IMG_H = 4;
    localparam int XW = 3;
    localparam int YW = 2;
    localparam int CW = 6;
    localparam int MIN_COUNT = 2;
    localparam int NPIX = IMG_W * IMG_H;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cfg_we = 1'b0;
    logic [4:0]    cfg_r = '0;
    logic [5:0]    cfg_g = '0;
    logic [4:0]    cfg_b = '0;
    logic [4:0]    r_min;
    logic [5:0]    g_max;
    logic [4:0]    b_max;
    logic          valid = 1'b0;
    logic          sof = 1'b0;
    logic          red = 1'b0;
    logic          busy;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic          res_found;
    logic [XW-1:0] res_xmin, res_xmax;
    logic [YW-1:0] res_ymin, res_ymax;
    logic [CW-1:0] res_count;
    logic          overrun;
    logic          sync_err;

    red_frame_ctrl #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .XW(XW), .YW(YW), .CW(CW), .MIN_COUNT(MIN_COUNT)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_cfg_we(cfg_we),
        .i_cfg_r_min(cfg_r), .i_cfg_g_max(cfg_g), .i_cfg_b_max(cfg_b),
        .o_r_min(r_min), .o_g_max(g_max), .o_b_max(b_max),
        .i_valid(valid), .i_sof(sof), .i_pixel_is_red(red),
        .o_busy(busy), .o_res_valid(res_valid), .i_res_ready(res_ready),
        .o_res_found(res_found), .o_res_xmin(res_xmin), .o_res_xmax(res_xmax),
        .o_res_ymin(res_ymin), .o_res_ymax(res_ymax), .o_res_count(res_count),
        .o_overrun(overrun), .o_sync_err(sync_err)
    );

    // Clock.
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int rdy_mode = 1;   // 0: ready low, 1: ready high, 2: random

    // Model state.
    int m_sh_r, m_sh_g, m_sh_b, m_act_r, m_act_g, m_act_b;
    bit m_in_frame;
    int m_pos;
    int m_px[$];
    int m_py[$];
    int e_valid, e_found, e_xmin, e_xmax, e_ymin, e_ymax, e_count, e_overrun, e_sync;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sh_r = 27; m_sh_g = 12; m_sh_b = 8;
        m_act_r = 27; m_act_g = 12; m_act_b = 8;
        m_in_frame = 0; m_pos = 0;
        m_px.delete(); m_py.delete();
        e_valid = 0; e_found = 0; e_xmin = 0; e_xmax = 0;
        e_ymin = 0; e_ymax = 0; e_count = 0; e_overrun = 0; e_sync = 0;
    endtask

    // One clock of the frame-level model, using the inputs just sampled.
    task automatic model_step();
        bit done;
        done = 0;
        e_overrun = 0;
        e_sync = 0;
        if (rst) begin
            model_reset();
            return;
        end
        if (valid && sof) begin
            if (m_in_frame && m_pos != 0) e_sync = 1;
            m_act_r = cfg_we ? int'(cfg_r) : m_sh_r;
            m_act_g = cfg_we ? int'(cfg_g) : m_sh_g;
            m_act_b = cfg_we ? int'(cfg_b) : m_sh_b;
            m_in_frame = 1;
            m_pos = 0;
            m_px.delete(); m_py.delete();
        end
        if (valid && m_in_frame) begin
            if (red) begin
                m_px.push_back(m_pos % IMG_W);
                m_py.push_back(m_pos / IMG_W);
            end
            m_pos++;
            if (m_pos == NPIX) begin
                done = 1;
                m_in_frame = 0;
                m_pos = 0;
            end
        end
        if (cfg_we) begin
            m_sh_r = int'(cfg_r); m_sh_g = int'(cfg_g); m_sh_b = int'(cfg_b);
        end
        if (done) begin
            e_overrun = (e_valid != 0 && !res_ready) ? 1 : 0;
            e_valid = 1;
            e_count = m_px.size();
            e_found = (e_count >= MIN_COUNT) ? 1 : 0;
            e_xmin = 0; e_xmax = 0; e_ymin = 0; e_ymax = 0;
            if (e_found != 0) begin
                e_xmin = IMG_W; e_ymin = IMG_H;
                foreach (m_px[i]) begin
                    if (m_px[i] < e_xmin) e_xmin = m_px[i];
                    if (m_px[i] > e_xmax) e_xmax = m_px[i];
                    if (m_py[i] < e_ymin) e_ymin = m_py[i];
                    if (m_py[i] > e_ymax) e_ymax = m_py[i];
                end
            end
        end else if (e_valid != 0 && res_ready) begin
            e_valid = 0;
        end
    endtask

    task automatic compare_all();
        check("r_min", int'(r_min), m_act_r);
        check("g_max", int'(g_max), m_act_g);
        check("b_max", int'(b_max), m_act_b);
        check("busy", int'(busy), int'(m_in_frame));
        check("res_valid", int'(res_valid), e_valid);
        check("res_found", int'(res_found), e_found);
        check("res_xmin", int'(res_xmin), e_xmin);
        check("res_xmax", int'(res_xmax), e_xmax);
        check("res_ymin", int'(res_ymin), e_ymin);
        check("res_ymax", int'(res_ymax), e_ymax);
        check("res_count", int'(res_count), e_count);
        check("overrun", int'(overrun), e_overrun);
        check("sync_err", int'(sync_err), e_sync);
    endtask

    // Drive ready, clock once, step model, sample #1 after the edge.
    task automatic cycle();
        if (rdy_mode == 2) res_ready = 1'($urandom_range(0, 1));
        else res_ready = (rdy_mode == 1);
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            valid = 1'b0;
            sof = 1'($urandom_range(0, 1));
            red = 1'($urandom_range(0, 1));
            cycle();
        end
        sof = 1'b0;
        red = 1'b0;
    endtask

    // Send beats start..start+n-1 of a frame; beat 0 carries SOF.
    task automatic run_frame(input int start, input int n, input bit [31:0] mask, input int gap_max);
        for (int idx = start; idx < start + n; idx++) begin
            if (gap_max > 0) idle($urandom_range(0, gap_max));
            valid = 1'b1;
            sof = (idx == 0);
            red = mask[idx];
            cycle();
        end
        valid = 1'b0;
        sof = 1'b0;
        red = 1'b0;
    endtask

    initial begin
        model_reset();
        // Reset
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        check("rst_r_min_lit", int'(r_min), 27);
        check("rst_g_max_lit", int'(g_max), 12);
        check("rst_b_max_lit", int'(b_max), 8);
        check("rst_valid_lit", int'(res_valid), 0);
        idle(2);

        // Frame with red at (3,0),(2,1),(5,3)
        rdy_mode = 0;
        run_frame(0, NPIX, 32'h2000_0408, 0);
        check("f1_valid_lit", int'(res_valid), 1);
        check("f1_found_lit", int'(res_found), 1);
        check("f1_xmin_lit", int'(res_xmin), 2);
        check("f1_xmax_lit", int'(res_xmax), 5);
        check("f1_ymin_lit", int'(res_ymin), 0);
        check("f1_ymax_lit", int'(res_ymax), 3);
        check("f1_count_lit", int'(res_count), 3);
        rdy_mode = 1;
        idle(1);
        check("f1_consumed_lit", int'(res_valid), 0);

        // Single red pixel at (7,3), then an empty frame
        run_frame(0, NPIX, 32'h8000_0000, 1);
        check("f2_found_lit", int'(res_found), 0);
        check("f2_xmax_lit", int'(res_xmax), 0);
        check("f2_count_lit", int'(res_count), 1);
        run_frame(0, NPIX, 32'h0, 1);
        check("f3_count_lit", int'(res_count), 0);

        // Mid-frame threshold write waits for the next SOF
        run_frame(0, 10, 32'h0, 0);
        cfg_we = 1'b1; cfg_r = 5'd20; cfg_g = 6'd12; cfg_b = 5'd8;
        idle(1);
        cfg_we = 1'b0;
        check("cfg_hold_lit", int'(r_min), 27);
        run_frame(10, NPIX - 10, 32'h0, 0);
        check("cfg_hold2_lit", int'(r_min), 27);
        run_frame(0, 1, 32'h0, 0);
        check("cfg_apply_lit", int'(r_min), 20);
        run_frame(1, NPIX - 1, 32'h0, 0);
        // Threshold write coincident with SOF
        cfg_we = 1'b1; cfg_r = 5'd5; cfg_g = 6'd40; cfg_b = 5'd17;
        run_frame(0, 1, 32'h0, 0);
        cfg_we = 1'b0;
        check("cfg_sof_r_lit", int'(r_min), 5);
        check("cfg_sof_g_lit", int'(g_max), 40);
        check("cfg_sof_b_lit", int'(b_max), 17);
        run_frame(1, NPIX - 1, 32'h0, 0);
        idle(1);

        // Early SOF at beat 13
        run_frame(0, 13, 32'hFFFF_FFFF, 1);
        run_frame(0, 1, 32'h0, 0);
        check("sync_err_lit", int'(sync_err), 1);
        check("sync_novalid_lit", int'(res_valid), 0);
        run_frame(1, NPIX - 1, 32'h0000_0402, 1);
        check("sync_count_lit", int'(res_count), 2);
        idle(1);

        // Two frames unconsumed -> overrun; completion with ready -> none
        rdy_mode = 0;
        run_frame(0, NPIX, 32'h0, 0);
        run_frame(0, NPIX, 32'h8010_0001, 0);
        check("ovr_pulse_lit", int'(overrun), 1);
        check("ovr_count_lit", int'(res_count), 3);
        check("ovr_xmax_lit", int'(res_xmax), 7);
        rdy_mode = 1;
        run_frame(0, NPIX, 32'h0, 0);
        check("no_ovr_lit", int'(overrun), 0);
        check("no_ovr_valid_lit", int'(res_valid), 1);

        // Reset mid-frame with a pending result and modified thresholds
        rdy_mode = 0;
        run_frame(0, NPIX, 32'h0000_0300, 2);
        cfg_we = 1'b1; cfg_r = 5'd3; cfg_g = 6'd60; cfg_b = 5'd30;
        run_frame(0, 17, 32'h00F0_0F00, 3);
        cfg_we = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("mrst_r_lit", int'(r_min), 27);
        check("mrst_busy_lit", int'(busy), 0);
        check("mrst_valid_lit", int'(res_valid), 0);
        check("mrst_count_lit", int'(res_count), 0);
        run_frame(5, 10, 32'hFFFF_FFFF, 2);
        check("nosof_busy_lit", int'(busy), 0);

        // Randomized frames, gaps, ready, config writes and early SOFs
        rdy_mode = 2;
        for (int f = 0; f < 12; f++) begin
            bit [31:0] mask;
            mask = $urandom();
            if ($urandom_range(0, 3) == 0) mask = mask & $urandom() & $urandom();
            if ($urandom_range(0, 2) == 0) begin
                cfg_we = 1'b1;
                cfg_r = 5'($urandom()); cfg_g = 6'($urandom()); cfg_b = 5'($urandom());
            end
            if ($urandom_range(0, 3) == 0)
                run_frame(0, $urandom_range(2, NPIX - 1), mask, 2);
            cfg_we = 1'b0;
            run_frame(0, NPIX, mask, $urandom_range(0, 3));
            idle($urandom_range(0, 3));
        end
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/red_frame_ctrl.md
# red_frame_ctrl

Frame-level controller for the red-pixel detector stage of the processing core. It owns the detector's colour thresholds and applies host updates only at frame boundaries. It tracks raster position of the detector's per-pixel output stream and accumulates red-pixel count and bounding box per frame. It hands each frame's result downstream over a valid/ready handshake.

## Interface
- IMG_W, 640, pixels per line
- IMG_H, 480, lines per frame
- XW, 10, x coordinate width; must satisfy 2^XW ≥ IMG_W
- YW, 9, y coordinate width; must satisfy 2^YW ≥ IMG_H
- CW, 19, red count width; must satisfy 2^CW > IMG_W*IMG_H
- MIN_COUNT, 16, minimum red pixels for a frame to report an object
- i_clk  in  1  clock; single clock domain
- i_rst  in  1  reset, synchronous, active-high
- i_cfg_we  in  1  write shadow thresholds
- i_cfg_r_min / i_cfg_g_max / i_cfg_b_max  in  5/6/5  shadow threshold data
- o_r_min / o_g_max / o_b_max  out  5/6/5  active thresholds driving the detector
- i_valid  in  1  detector output beat valid
- i_sof  in  1  beat is pixel (0,0); qualified by i_valid
- i_pixel_is_red  in  1  detector decision for this beat
- o_busy  out  1  frame in progress
- o_res_valid  out  1  result available
- i_res_ready  in  1  downstream accepts result
- o_res_found  out  1  count ≥ MIN_COUNT
- o_res_xmin, o_res_xmax  out  XW  bounding box x
- o_res_ymin, o_res_ymax  out  YW  bounding box y
- o_res_count  out  CW  red pixels in frame
- o_overrun  out  1  one-cycle pulse: unconsumed result overwritten
- o_sync_err  out  1  one-cycle pulse: frame aborted by early i_sof

## Operation
- Reset values: o_r_min=27, o_g_max=12, o_b_max=8, shadow thresholds are the same values, state IDLE, o_busy=0, o_res_valid=0, all result fields 0, pulses 0.
- Shadow: i_cfg_we loads shadow regs any cycle. Active regs load from shadow on every accepted SOF beat. If i_cfg_we and the SOF beat coincide, the new i_cfg_* values go straight to active.
- States: IDLE, ACTIVE.
- IDLE: ignore beats without i_sof. On i_valid&i_sof: load thresholds, x=y=0 processed as the first beat, enter ACTIVE.
- ACTIVE: each i_valid beat is processed at (x,y), then x increments; at x=IMG_W-1, x wraps to 0 and y increments. Cycles without i_valid hold all state.
- Beat processing: if i_pixel_is_red, count+1. The first red pixel in the frame sets xmin=xmax=x and ymin=ymax=y. Later red pixels update min/max by unsigned compare.
- SOF beat starts the accumulators fresh: count=0 before the beat is applied, box invalid.
- Last beat (IMG_W-1, IMG_H-1) is processed, results are latched into the output regs, o_res_valid=1, return to IDLE.
- Latch rule: o_res_found = (count ≥ MIN_COUNT). Box fields are the accumulated values if found, else all 0. o_res_count is always the true count.
- Early SOF: i_valid&i_sof in ACTIVE at any position other than (0,0) pulses o_sync_err. The partial frame is discarded with no result, and the beat restarts as a new frame with thresholds reloaded.
- Handshake: the result is consumed on o_res_valid&i_res_ready, which clears o_res_valid next cycle. Fields are stable while o_res_valid=1.
- Overrun: a new frame completes while o_res_valid=1 and is not accepted that cycle. The new result overwrites, o_res_valid stays 1, and o_overrun pulses. Acceptance in the same cycle as completion gives no overrun and o_res_valid stays 1 with the new data.
- i_rst mid-frame: everything returns to reset values next cycle, including thresholds and any pending result.

## Timing
- i_sof and i_pixel_is_red are aligned with i_valid at this block's ports. Upstream delays the SOF flag by the detector's 1-cycle latency.
- Threshold update is visible on o_* the cycle after the SOF beat.
- Result fields and o_res_valid are registered, valid the cycle after the last beat.
- o_busy=1 from the cycle after SOF until the cycle after the last beat.
- Pulses are registered, 1 cycle wide, and appear the cycle after the causing beat.
- Throughput is one beat per cycle with no stall output. The block never backpressures the pixel stream.

## Test plan
IMG_W=8, IMG_H=4, MIN_COUNT=2 unless noted.
- Reset, then a frame with red at (2,1),(5,3),(3,0) -> o_res_valid the cycle after beat 31, found=1, xmin=2, xmax=5, ymin=0, ymax=3, count=3.
- Frame with a single red pixel at (7,3) -> found=0, box fields 0, count=1. Frame with no red -> count=0.
- i_cfg_we r_min=20 mid-frame -> o_r_min stays 27 until the next SOF, then becomes 20. i_cfg_we on the SOF beat -> applied the next cycle.
- SOF at beat 13 of a frame -> o_sync_err pulse, no result for the partial frame, the next result covers 32 beats from the new SOF.
- i_res_ready=0 for two full frames -> o_overrun pulses at the second frame end, fields show frame 2. Ready high at completion -> no overrun.
- i_valid gaps of random length plus i_rst asserted at beat 17 -> all outputs return to reset values. Beats without SOF are ignored until the next SOF.
